// File: rtl/m_ext_seq.sv
// m_ext_seq: multi-cycle RV32M sequencer (shift-add multiply, restoring divide)
module m_ext_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
  state_t r_state, w_next;
  logic [2:0] r_f3;
  logic [XLEN-1:0] r_a, r_b, r_result;
  logic r_neg, r_sa;
  logic [CW-1:0] r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic w_go, w_sa, w_sb, w_zero, w_ovf, w_fast;
  logic [XLEN-1:0] w_abs_a, w_abs_b, w_fast_res, w_quo, w_rem, w_fix_res;
  logic [XLEN:0] w_msum, w_part, w_trial;
  logic [2*XLEN-1:0] w_mul_next, w_div_next, w_prod;
  // MULH and DIV/REM treat both operands as signed, MULHSU only rs1
  assign w_sa = funct3_i[2] ? ~funct3_i[0] & rs1_i[XLEN-1]
                            : (funct3_i[1:0] == 2'b01 || funct3_i[1:0] == 2'b10) & rs1_i[XLEN-1];
  assign w_sb = funct3_i[2] ? ~funct3_i[0] & rs2_i[XLEN-1]
                            : (funct3_i[1:0] == 2'b01) & rs2_i[XLEN-1];
  assign w_abs_a = w_sa ? -rs1_i : rs1_i;
  assign w_abs_b = w_sb ? -rs2_i : rs2_i;
  assign w_go = start_i & (r_state == S_IDLE) & ~flush_i;
  assign w_zero = rs2_i == '0;
  assign w_ovf = funct3_i[2] & ~funct3_i[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_i);
  assign w_fast = funct3_i[2] & (w_zero | w_ovf);
  // divide-by-zero: q=~0, r=rs1; overflow: q=rs1 (0x80..0), r=0
  assign w_fast_res = w_zero ? (funct3_i[1] ? rs1_i : '1) : (funct3_i[1] ? '0 : rs1_i);
  // multiply step: acc = {hi, multiplier}; add multiplicand into hi, shift right
  assign w_msum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mul_next = {w_msum, r_acc[XLEN-1:1]};
  // divide step: acc = {rem, quo}; shift left, trial-subtract divisor
  assign w_part = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_trial = w_part - {1'b0, r_b};
  assign w_div_next = w_trial[XLEN] ? {w_part[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                    : {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quo = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem = r_sa ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
  assign w_fix_res = r_f3[2] ? (r_f3[1] ? w_rem : w_quo)
                             : (r_f3[1:0] == 2'b00 ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
  assign stall_o = w_go | (r_state == S_CALC) | (r_state == S_FIX);
  assign busy_o = r_state != S_IDLE;
  assign done_o = r_state == S_DONE;
  assign result_o = r_result;
  // next-state: flush aborts CALC/FIX, DONE always returns to IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = w_go ? (w_fast ? S_DONE : S_CALC) : S_IDLE;
      S_CALC: w_next = flush_i ? S_IDLE : (r_cnt == LAST ? S_FIX : S_CALC);
      S_FIX:  w_next = flush_i ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // operand capture, iteration datapath and result register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_f3 <= '0;
      r_a <= '0;
      r_b <= '0;
      r_neg <= 1'b0;
      r_sa <= 1'b0;
      r_cnt <= '0;
      r_acc <= '0;
      r_result <= '0;
    end else begin
      if (w_go) begin
        r_f3 <= funct3_i;
        r_a <= w_abs_a;
        r_b <= w_abs_b;
        r_neg <= w_sa ^ w_sb;
        r_sa <= w_sa;
        r_cnt <= '0;
        r_acc <= {{XLEN{1'b0}}, funct3_i[2] ? w_abs_a : w_abs_b};
        if (w_fast) r_result <= w_fast_res;
      end
      if (r_state == S_CALC) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= r_f3[2] ? w_div_next : w_mul_next;
      end
      if (r_state == S_FIX && !flush_i) r_result <= w_fix_res;
    end
  end
endmodule

// File: tb/tb_m_ext_seq.sv
// tb_m_ext_seq: directed self-checking bench for the RV32M sequencer
module tb_m_ext_seq;
  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  logic start_i = 1'b0;
  logic flush_i = 1'b0;
  logic [2:0] funct3_i = '0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic stall_o, busy_o, done_o;
  logic [31:0] result_o;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_done = 0;
  int first_done;
  m_ext_seq #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .funct3_i(funct3_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i), .stall_o(stall_o),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp_res, input int exp_lat, input bit poke);
    int n;
    int st;
    st = 0;
    @(negedge clk_i);
    start_i = 1'b1; funct3_i = f; rs1_i = a; rs2_i = b;
    #1;
    chk({tag, ".stall0"}, 32'(stall_o), 32'd1);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n = 1;
    while (!done_o && n < 100) begin
      st += int'(stall_o);
      @(posedge clk_i); #1;
      n++;
    end
    last_done = cyc;
    chk({tag, ".lat"}, 32'(n), 32'(exp_lat));
    chk({tag, ".stalls"}, 32'(st), 32'(exp_lat - 1));
    chk({tag, ".stall_done"}, 32'(stall_o), 32'd0);
    chk({tag, ".res"}, result_o, exp_res);
    if (poke) begin
      start_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd3; rs2_i = 32'd3;
    end
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk({tag, ".done_off"}, 32'(done_o), 32'd0);
    chk({tag, ".idle"}, 32'(busy_o), 32'd0);
  endtask
  initial begin
    #12;
    chk("rst.res", result_o, 32'd0);
    chk("rst.busy", 32'(busy_o), 32'd0);
    chk("rst.done", 32'(done_o), 32'd0);
    chk("rst.stall", 32'(stall_o), 32'd0);
    @(negedge clk_i); rst_n_i = 1'b1;
    op("mul", 3'b000, 32'd7, 32'd6, 32'h0000002A, 34, 1'b0);
    op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1'b0);
    op("mulh", 3'b001, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 34, 1'b0);
    op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 34, 1'b0);
    op("mul_min", 3'b000, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, 1'b0);
    op("div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, 1'b0);
    op("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, 1'b0);
    op("divu", 3'b101, 32'd100, 32'd7, 32'd14, 34, 1'b0);
    op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 34, 1'b0);
    op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0);
    op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 1'b0);
    op("divu_z", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 1'b0);
    op("rem_z", 3'b110, 32'd5, 32'd0, 32'd5, 1, 1'b0);
    @(negedge clk_i);
    start_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd3; rs2_i = 32'd5;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (9) begin @(posedge clk_i); #1; end
    flush_i = 1'b1;
    chk("flush.busy_pre", 32'(busy_o), 32'd1);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    chk("flush.busy", 32'(busy_o), 32'd0);
    chk("flush.done", 32'(done_o), 32'd0);
    chk("flush.res", result_o, 32'd5);
    @(negedge clk_i);
    start_i = 1'b1; flush_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush_start.busy", 32'(busy_o), 32'd0);
    op("after_flush", 3'b000, 32'd3, 32'd5, 32'h0000000F, 34, 1'b0);
    @(negedge clk_i);
    start_i = 1'b1; funct3_i = 3'b101; rs1_i = 32'd100; rs2_i = 32'd7;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (5) begin @(posedge clk_i); #1; end
    rst_n_i = 1'b0;
    #1;
    chk("arst.res", result_o, 32'd0);
    chk("arst.busy", 32'(busy_o), 32'd0);
    chk("arst.done", 32'(done_o), 32'd0);
    chk("arst.stall", 32'(stall_o), 32'd0);
    @(negedge clk_i); rst_n_i = 1'b1;
    op("b2b_a", 3'b000, 32'd9, 32'd9, 32'h00000051, 34, 1'b1);
    first_done = last_done;
    op("b2b_b", 3'b000, 32'h00012345, 32'h10, 32'h00123450, 34, 1'b0);
    chk("b2b.spacing", 32'(last_done - first_done), 32'd35);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
